fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter, drives the instruction memory's chip-enable and byte address, and captures the returned word into the IF/ID pipeline register. Redirects come from two places: branch/jump redirects from ID, which preserve MIPS delay-slot semantics, and exception redirects from the exception unit. Stalls come from the hazard unit.

---
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program
//   counter, drives the instruction memory chip-enable and byte address, and
//   captures the returned word into the IF/ID pipeline register. Branch/jump
//   redirects from ID keep delay-slot semantics (the word fetched in the
//   redirect cycle still enters ID). Exception redirects flush IF/ID and
//   override a hazard stall.
//
// Ports
//   clk         in   system clock, all state updates on the rising edge
//   rst         in   synchronous active-high reset
//   stall       in   hazard unit: hold PC and IF/ID
//   br_taken    in   ID: branch/jump resolved taken this cycle
//   br_target   in   ID: redirect address
//   exc_req     in   exception unit: redirect and flush
//   exc_target  in   exception handler / EPC address
//   inst_ce     out  instruction memory chip-enable
//   inst_addr   out  instruction memory byte address (current PC)
//   inst_data   in   instruction memory read data (combinational from inst_addr)
//   id_pc       out  PC of the instruction held in IF/ID
//   id_inst     out  instruction held in IF/ID
//   id_valid    out  IF/ID holds a real fetched instruction
//   id_adel     out  IF/ID entry was fetched from a misaligned PC
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic [31:0] exc_target,
  output logic        inst_ce,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_adel
);

  logic [31:0] pc_q,       pc_d;
  logic        ce_q,       ce_d;
  logic [31:0] id_pc_q,    id_pc_d;
  logic [31:0] id_inst_q,  id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        id_adel_q,  id_adel_d;

  logic        pc_misaligned_s;
  logic [31:0] fetch_word_s;
  logic [31:0] pc_plus4_s;

  assign pc_misaligned_s = (pc_q[1:0] != 2'b00);
  // A misaligned fetch never reaches memory, so substitute the NOP word.
  assign fetch_word_s    = pc_misaligned_s ? NOP_WORD : inst_data;
  // Natural 32-bit wrap: 0xFFFF_FFFC + 4 -> 0x0000_0000.
  assign pc_plus4_s      = pc_q + 32'd4;

  assign inst_addr = pc_q;
  assign inst_ce   = ce_q & ~pc_misaligned_s;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;
  assign id_valid  = id_valid_q;
  assign id_adel   = id_adel_q;

  // Next-state selection: exception > stall > boot bubble > normal fetch.
  always_comb begin
    pc_d       = pc_q;
    ce_d       = ce_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    id_adel_d  = id_adel_q;
    if (exc_req) begin
      pc_d       = exc_target;
      ce_d       = 1'b1;
      id_pc_d    = 32'h0000_0000;
      id_inst_d  = NOP_WORD;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
    end else if (stall) begin
      // Hold everything; a br_taken seen here is re-presented by ID later.
      pc_d = pc_q;
    end else if (!ce_q) begin
      // First cycle after reset: enable memory, push a bubble into ID.
      ce_d       = 1'b1;
      id_inst_d  = NOP_WORD;
      id_valid_d = 1'b0;
    end else begin
      // Delay slot: the word fetched this cycle enters ID even on a redirect.
      id_pc_d    = pc_q;
      id_inst_d  = fetch_word_s;
      id_valid_d = 1'b1;
      id_adel_d  = pc_misaligned_s;
      pc_d       = br_taken ? br_target : pc_plus4_s;
    end
  end

  // State registers with synchronous reset taking priority over all requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      ce_q       <= 1'b0;
      id_pc_q    <= 32'h0000_0000;
      id_inst_q  <= NOP_WORD;
      id_valid_q <= 1'b0;
      id_adel_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ce_q       <= ce_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      id_adel_q  <= id_adel_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed bench for fetch_stage. A 64-word instruction memory answers
//   combinationally from inst_addr[7:2]. Inputs are driven 1 time unit after
//   each rising edge and outputs are checked at that same point.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic [31:0] exc_target;
  logic        inst_ce;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_adel;

  logic [31:0] mem [0:63];
  int checks;
  int failures;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .exc_req    (exc_req),
    .exc_target (exc_target),
    .inst_ce    (inst_ce),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_valid   (id_valid),
    .id_adel    (id_adel)
  );

  assign inst_data = mem[inst_addr[7:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks a full IF/ID entry plus the current fetch address/enable.
  task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                        input logic vld, input logic adel,
                        input logic [31:0] addr, input logic ce);
    chk({tag, ".id_pc"},    id_pc, pc);
    chk({tag, ".id_inst"},  id_inst, inst);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, vld});
    chk({tag, ".id_adel"},  {31'd0, id_adel}, {31'd0, adel});
    chk({tag, ".inst_addr"}, inst_addr, addr);
    chk({tag, ".inst_ce"},  {31'd0, inst_ce}, {31'd0, ce});
  endtask

  // Called with rst already deasserted and the DUT in reset state.
  task automatic boot_seq(input string tag);
    step();  // boot edge: ce rises, bubble in ID
    chk_id({tag, ".boot"}, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    chk_id({tag, ".f0"}, 32'h0, 32'h0000f025, 1'b1, 1'b0, 32'h4, 1'b1);
    step();
    chk_id({tag, ".f1"}, 32'h4, 32'h241d1000, 1'b1, 1'b0, 32'h8, 1'b1);
    step();
    chk_id({tag, ".f2"}, 32'h8, 32'h8f990008, 1'b1, 1'b0, 32'hC, 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = 32'h0000f025;
    mem[1] = 32'h241d1000;
    mem[2] = 32'h8f990008;

    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    exc_req = 1'b0; exc_target = 32'h0;

    // Reset state
    step();
    step();
    chk_id("reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    boot_seq("first");

    // Stall 3 cycles with id_pc=0x8, pc=0xC
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_id("stall", 32'h8, 32'h8f990008, 1'b1, 1'b0, 32'hC, 1'b1);
    end
    stall = 1'b0;
    step();
    chk_id("unstall", 32'hC, 32'hA500_0003, 1'b1, 1'b0, 32'h10, 1'b1);

    // Branch sampled while pc=0x10: delay slot then target, no bubble
    br_taken = 1'b1; br_target = 32'h50;
    step();
    chk_id("br.slot", 32'h10, 32'hA500_0004, 1'b1, 1'b0, 32'h50, 1'b1);
    br_taken = 1'b0;
    step();
    chk_id("br.tgt", 32'h50, 32'hA500_0014, 1'b1, 1'b0, 32'h54, 1'b1);
    step();
    chk_id("br.tgt4", 32'h54, 32'hA500_0015, 1'b1, 1'b0, 32'h58, 1'b1);

    // Exception together with stall: exception wins
    exc_req = 1'b1; exc_target = 32'h90; stall = 1'b1;
    step();
    chk_id("exc.flush", 32'h0, 32'h0, 1'b0, 1'b0, 32'h90, 1'b1);
    exc_req = 1'b0; stall = 1'b0;
    step();
    chk_id("exc.hdl", 32'h90, 32'hA500_0024, 1'b1, 1'b0, 32'h94, 1'b1);

    // Misaligned branch target
    br_taken = 1'b1; br_target = 32'h52;
    step();
    chk_id("mis.slot", 32'h94, 32'hA500_0025, 1'b1, 1'b0, 32'h52, 1'b0);
    br_taken = 1'b0;
    step();
    chk_id("mis.adel", 32'h52, 32'h0, 1'b1, 1'b1, 32'h56, 1'b0);

    // Recover via exception to 0x40
    exc_req = 1'b1; exc_target = 32'h40;
    step();
    chk_id("rec.flush", 32'h0, 32'h0, 1'b0, 1'b0, 32'h40, 1'b1);
    exc_req = 1'b0;

    // Reset mid-stream at pc=0x40 with a branch pending
    rst = 1'b1; br_taken = 1'b1; br_target = 32'h50;
    step();
    chk_id("midrst", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0; br_taken = 1'b0;
    boot_seq("restart");

    // PC wrap at top of address space
    exc_req = 1'b1; exc_target = 32'hFFFF_FFFC;
    step();
    chk_id("wrap.flush", 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1);
    exc_req = 1'b0;
    step();
    chk_id("wrap", 32'hFFFF_FFFC, 32'hA500_003F, 1'b1, 1'b0, 32'h0, 1'b1);

    // Stall with br_taken: redirect is dropped
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h80;
    step();
    chk_id("stallbr", 32'hFFFF_FFFC, 32'hA500_003F, 1'b1, 1'b0, 32'h0, 1'b1);
    stall = 1'b0; br_taken = 1'b0;
    step();
    chk_id("stallbr.after", 32'h0, 32'h0000f025, 1'b1, 1'b0, 32'h4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
